uriscv_lsu_mem_ctrl: RTL and testbench
======================================

// Module: uriscv_lsu_mem_ctrl
// PURPOSE
//  Downstream of the LSU decode stage: captures one load/store request (address, byte strobes, aligned write data,
//  misaligned flag), runs it on the data bus with a request/accept/ack handshake and stalls the core meanwhile.
//  Aligns and sign-/zero-extends load data for register writeback; raises misaligned and access faults.
// PARAMETERS
//  TIMEOUT_CYCLES  256  bus cycles before a hung access is aborted (used only with URISCV_LSU_TIMEOUT_EN)
// PORTS
//  clk_i             in   1   clock
//  rst_n_i           in   1   asynchronous active-low reset
//  req_valid_i       in   1   one-cycle issue strobe from core; only sampled when busy_o=0
//  req_funct3_i      in   3   load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//  req_rd_i          in   5   load destination register
//  mem_rd_i          in   1   load request from LSU decode
//  mem_wr_i          in   4   store byte strobes from LSU decode
//  mem_addr_i        in   32  byte address
//  mem_data_i        in   32  lane-aligned store data
//  mem_misaligned_i  in   1   misaligned access flag
//  bus_addr_o        out  32  word address {addr[31:2],2'b00}
//  bus_data_wr_o     out  32  store data
//  bus_rd_o          out  1   read strobe
//  bus_wr_o          out  4   write byte strobes
//  bus_accept_i      in   1   slave accepts the strobed request this cycle
//  bus_ack_i         in   1   response valid this cycle
//  bus_error_i       in   1   response is an error (qualified by bus_ack_i)
//  bus_data_rd_i     in   32  read data (qualified by bus_ack_i)
//  busy_o            out  1   state!=IDLE; core holds its pipeline
//  wb_valid_o        out  1   one-cycle load writeback pulse
//  wb_rd_o           out  5   writeback register
//  wb_data_o         out  32  extended load result
//  fault_o           out  1   one-cycle fault pulse
//  fault_cause_o     out  4   4 ld-misaligned, 5 ld-access, 6 st-misaligned, 7 st-access
//  fault_addr_o      out  32  full byte address of the faulting access
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, timeout counter 0. Reset mid-access drops bus strobes immediately.
//  - All outputs are registered; busy_o is decoded from the state register.
//  - IDLE: on req_valid_i with mem_rd_i|(|mem_wr_i):
//    - misaligned: no bus cycle; next cycle fault_o=1 with cause 4 or 6, fault_addr_o=mem_addr_i; stay in IDLE.
//    - otherwise: capture addr, data, strobes, funct3, rd; go to REQ; bus strobes high from the next cycle.
//    - req_valid_i with no rd/wr: ignored. req_valid_i while busy_o=1: ignored.
//  - REQ: hold strobes, addr and data stable until bus_accept_i, then drop them.
//    - accept and ack in the same cycle: complete directly; otherwise go to WAIT.
//  - WAIT: no strobes; on bus_ack_i complete. Acks arriving in IDLE are ignored.
//  - Completion (next cycle, back to IDLE):
//    - bus_error_i=1: fault_o with cause 5 (load) or 7 (store); no writeback.
//    - load: wb_valid_o=1, wb_rd_o=rd; byte lane is addr[1:0], half lane is addr[1].
//      lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
//    - store: no pulse; busy_o falls.
//  - Minimum latency: issue N, strobe N+1, zero-wait ack N+1, wb_valid_o and busy_o=0 at N+2.
//  - wb_valid_o and fault_o are never high together; wb_data_o holds its last value between pulses.
// CONFIGURATION
//  URISCV_LSU_TIMEOUT_EN defined:
//   - counter cleared on leaving IDLE, +1 each cycle in REQ/WAIT.
//   - reaching TIMEOUT_CYCLES-1 without completion: drop strobes, fault cause 5/7, back to IDLE.
//   - a later ack is ignored.
//  Not defined: no counter; REQ/WAIT wait indefinitely.
// TESTING
//  1. lb, addr 0x1003, rd=5, data 0x80FF_FF12, zero-wait bus -> bus_addr 0x1000, wb_data 0xFFFF_FF80 at N+2.
//  2. lhu, addr 0x2002, data 0xBEEF_1234; accept at N+3, ack at N+6 -> wb_data 0x0000_BEEF; busy_o high N+1..N+6.
//  3. sb strobes 4'b0100, data 0x0055_0000 -> bus_wr_o=0100 held until accept; no wb_valid_o/fault_o.
//  4. lw with misaligned=1, addr 0x3001 -> no bus strobe; fault_o at N+1, cause 4, fault_addr 0x3001.
//  5. sw, ack with bus_error_i=1 -> fault cause 7; then lw issued next cycle completes normally.
//  6. TIMEOUT_EN, TIMEOUT_CYCLES=8, never ack -> cause 5 after 8 cycles; late ack ignored. rst_n_i low in WAIT -> all 0.

Source files
------------

// File: rtl/uriscv_lsu_mem_ctrl.sv
// rtl/uriscv_lsu_mem_ctrl.sv - LSU bus sequencer with load alignment/extension and fault reporting
// Optional access timeout enabled by defining URISCV_LSU_TIMEOUT_EN.
module uriscv_lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [4:0]  req_rd_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_misaligned_i,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_wr_o,
  output logic        bus_rd_o,
  output logic [3:0]  bus_wr_o,
  input  logic        bus_accept_i,
  input  logic        bus_ack_i,
  input  logic        bus_error_i,
  input  logic [31:0] bus_data_rd_i,
  output logic        busy_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        fault_o,
  output logic [3:0]  fault_cause_o,
  output logic [31:0] fault_addr_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_is_load;

  logic        w_issue;
  logic        w_done;
  logic        w_abort;
  logic        w_timeout;
  logic [31:0] w_load_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

`ifdef URISCV_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_tmo_cnt;
  assign w_timeout = (r_tmo_cnt == TMO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign busy_o  = (r_state != ST_IDLE);
  assign w_issue = req_valid_i && (r_state == ST_IDLE) && (mem_rd_i || (|mem_wr_i));
  assign w_done  = ((r_state == ST_REQ) && bus_accept_i && bus_ack_i) ||
                   ((r_state == ST_WAIT) && bus_ack_i);
  assign w_abort = busy_o && !w_done && w_timeout;

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0:    w_byte = bus_data_rd_i[7:0];
      2'd1:    w_byte = bus_data_rd_i[15:8];
      2'd2:    w_byte = bus_data_rd_i[23:16];
      default: w_byte = bus_data_rd_i[31:24];
    endcase
    w_half = r_addr[1] ? bus_data_rd_i[31:16] : bus_data_rd_i[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = bus_data_rd_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_funct3      <= '0;
      r_rd          <= '0;
      r_is_load     <= 1'b0;
      bus_addr_o    <= '0;
      bus_data_wr_o <= '0;
      bus_rd_o      <= 1'b0;
      bus_wr_o      <= '0;
      wb_valid_o    <= 1'b0;
      wb_rd_o       <= '0;
      wb_data_o     <= '0;
      fault_o       <= 1'b0;
      fault_cause_o <= '0;
      fault_addr_o  <= '0;
`ifdef URISCV_LSU_TIMEOUT_EN
      r_tmo_cnt     <= '0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
      fault_o    <= 1'b0;
      if (busy_o) begin
`ifdef URISCV_LSU_TIMEOUT_EN
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
        if (w_done || w_abort) begin
          r_state  <= ST_IDLE;
          bus_rd_o <= 1'b0;
          bus_wr_o <= '0;
          if (w_abort || bus_error_i) begin
            fault_o       <= 1'b1;
            fault_cause_o <= r_is_load ? 4'd5 : 4'd7;
            fault_addr_o  <= r_addr;
          end else if (r_is_load) begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= r_rd;
            wb_data_o  <= w_load_data;
          end
        end else if ((r_state == ST_REQ) && bus_accept_i) begin
          r_state  <= ST_WAIT;
          bus_rd_o <= 1'b0;
          bus_wr_o <= '0;
        end
      end else if (w_issue) begin
        if (mem_misaligned_i) begin
          fault_o       <= 1'b1;
          fault_cause_o <= mem_rd_i ? 4'd4 : 4'd6;
          fault_addr_o  <= mem_addr_i;
        end else begin
          r_state       <= ST_REQ;
          r_addr        <= mem_addr_i;
          r_funct3      <= req_funct3_i;
          r_rd          <= req_rd_i;
          r_is_load     <= mem_rd_i;
          bus_addr_o    <= {mem_addr_i[31:2], 2'b00};
          bus_data_wr_o <= mem_data_i;
          bus_rd_o      <= mem_rd_i;
          bus_wr_o      <= mem_rd_i ? 4'b0000 : mem_wr_i;
`ifdef URISCV_LSU_TIMEOUT_EN
          r_tmo_cnt     <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_uriscv_lsu_mem_ctrl.sv
// tb/tb_uriscv_lsu_mem_ctrl.sv - scoreboard bench for uriscv_lsu_mem_ctrl
// Timeout scenario runs only when URISCV_LSU_TIMEOUT_EN is defined.
module tb_uriscv_lsu_mem_ctrl;

`ifdef URISCV_LSU_TIMEOUT_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 256;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        mem_rd_i = 1'b0;
  logic [3:0]  mem_wr_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        mem_misaligned_i = 1'b0;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_wr_o;
  logic        bus_rd_o;
  logic [3:0]  bus_wr_o;
  logic        bus_accept_i = 1'b0;
  logic        bus_ack_i = 1'b0;
  logic        bus_error_i = 1'b0;
  logic [31:0] bus_data_rd_i = '0;
  logic        busy_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        fault_o;
  logic [3:0]  fault_cause_o;
  logic [31:0] fault_addr_o;

  uriscv_lsu_mem_ctrl #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i),
    .req_funct3_i(req_funct3_i), .req_rd_i(req_rd_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_misaligned_i(mem_misaligned_i), .bus_addr_o(bus_addr_o),
    .bus_data_wr_o(bus_data_wr_o), .bus_rd_o(bus_rd_o), .bus_wr_o(bus_wr_o),
    .bus_accept_i(bus_accept_i), .bus_ack_i(bus_ack_i), .bus_error_i(bus_error_i),
    .bus_data_rd_i(bus_data_rd_i), .busy_o(busy_o), .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .fault_o(fault_o),
    .fault_cause_o(fault_cause_o), .fault_addr_o(fault_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        fault;
    logic [3:0]  cause;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*a[1:0] +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (rst_n_i && (wb_valid_o || fault_o)) begin
      check_eq("wb_and_fault", {31'h0, wb_valid_o && fault_o}, 32'h0);
      if (sb_q.size() == 0) begin
        check_eq("spurious_result", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.fault) begin
          check_eq("fault_o", {31'h0, fault_o}, 32'h1);
          check_eq("fault_cause", {28'h0, fault_cause_o}, {28'h0, e.cause});
          check_eq("fault_addr", fault_addr_o, e.addr);
        end else begin
          check_eq("wb_valid", {31'h0, wb_valid_o}, 32'h1);
          check_eq("wb_rd", {27'h0, wb_rd_o}, {27'h0, e.rd});
          check_eq("wb_data", wb_data_o, e.data);
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic mis, input logic [2:0] f3,
                       input logic [4:0] rdreg);
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr; mem_addr_i = addr;
    mem_data_i = wdata; mem_misaligned_i = mis; req_funct3_i = f3; req_rd_i = rdreg;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = '0; mem_misaligned_i = 1'b0;
  endtask

  task automatic access(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input logic [4:0] rdreg,
                        input int acc_dly, input int ack_dly, input logic err,
                        input logic [31:0] rdata);
    exp_t e;
    e.fault = err; e.cause = rd ? 4'd5 : 4'd7; e.addr = addr; e.rd = rdreg;
    e.data = ref_load(f3, addr, rdata);
    if (err || rd) sb_q.push_back(e);
    issue(rd, wr, addr, wdata, 1'b0, f3, rdreg);
    for (int c = 0; c <= ack_dly; c++) begin
      bus_accept_i = (c == acc_dly);
      bus_ack_i = (c == ack_dly);
      bus_error_i = err;
      bus_data_rd_i = (c == ack_dly) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk_i);
      check_eq("busy_active", {31'h0, busy_o}, 32'h1);
      if (c <= acc_dly) begin
        check_eq("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
        check_eq("bus_strobes", {27'h0, bus_rd_o, bus_wr_o}, {27'h0, rd, wr});
        if (!rd) check_eq("bus_wdata", bus_data_wr_o, wdata);
      end else begin
        check_eq("bus_strobes_wait", {27'h0, bus_rd_o, bus_wr_o}, 32'h0);
      end
      @(posedge clk_i); #1;
    end
    bus_accept_i = 1'b0; bus_ack_i = 1'b0; bus_error_i = 1'b0;
    @(negedge clk_i);
    check_eq("busy_done", {31'h0, busy_o}, 32'h0);
    check_eq("bus_strobes_done", {27'h0, bus_rd_o, bus_wr_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [2:0]  f3;
    logic [31:0] a;
    int          busy_cnt;

    #1;
    check_eq("rst_outputs", {bus_addr_o | bus_data_wr_o | wb_data_o | fault_addr_o},
             32'h0);
    check_eq("rst_flags", {19'h0, bus_rd_o, bus_wr_o, busy_o, wb_valid_o, fault_o,
             fault_cause_o}, 32'h0);
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    access(1'b1, 4'h0, 32'h0000_1003, 32'h0, 3'b000, 5'd5, 0, 0, 1'b0, 32'h80FF_FF12);
    access(1'b1, 4'h0, 32'h0000_2002, 32'h0, 3'b101, 5'd6, 2, 5, 1'b0, 32'hBEEF_1234);
    access(1'b0, 4'b0100, 32'h0000_4002, 32'h0055_0000, 3'b000, 5'd0, 3, 3, 1'b0, 32'h0);

    e.fault = 1'b1; e.cause = 4'd4; e.addr = 32'h0000_3001; e.rd = '0; e.data = '0;
    sb_q.push_back(e);
    issue(1'b1, 4'h0, 32'h0000_3001, 32'h0, 1'b1, 3'b010, 5'd7);
    @(negedge clk_i);
    check_eq("mis_no_strobe", {27'h0, bus_rd_o, bus_wr_o}, 32'h0);
    check_eq("mis_not_busy", {31'h0, busy_o}, 32'h0);

    e.fault = 1'b1; e.cause = 4'd6; e.addr = 32'h0000_3102;
    sb_q.push_back(e);
    issue(1'b0, 4'b1111, 32'h0000_3102, 32'h0, 1'b1, 3'b010, 5'd0);

    access(1'b0, 4'b1111, 32'h0000_5000, 32'hCAFE_F00D, 3'b010, 5'd0, 0, 0, 1'b1, 32'h0);
    access(1'b1, 4'h0, 32'h0000_6000, 32'h0, 3'b010, 5'd9, 0, 0, 1'b0, 32'h1357_9BDF);
    access(1'b1, 4'h0, 32'h0000_6004, 32'h0, 3'b010, 5'd10, 1, 2, 1'b1, 32'h0);

    issue(1'b0, 4'h0, 32'h0000_7000, 32'h0, 1'b0, 3'b010, 5'd1);
    @(negedge clk_i);
    check_eq("noop_ignored", {31'h0, busy_o}, 32'h0);
    @(posedge clk_i); #1 bus_ack_i = 1'b1; bus_error_i = 1'b1;
    @(posedge clk_i); #1 bus_ack_i = 1'b0; bus_error_i = 1'b0;
    @(negedge clk_i);
    check_eq("idle_ack_ignored", {30'h0, busy_o, fault_o}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = {$urandom_range(0, 32'h3FFF), 2'b00} | 32'h0001_0000;
      if (f3 == 3'b000 || f3 == 3'b100) a[1:0] = 2'($urandom_range(0, 3));
      else if (f3 != 3'b010) a[1] = 1'($urandom_range(0, 1));
      access(1'b1, 4'h0, a, 32'h0, f3, 5'($urandom_range(1, 31)),
             i % 3, (i % 3) + (i % 2), 1'b0, $urandom);
    end

`ifdef URISCV_LSU_TIMEOUT_EN
    e.fault = 1'b1; e.cause = 4'd5; e.addr = 32'h0000_8008;
    sb_q.push_back(e);
    issue(1'b1, 4'h0, 32'h0000_8008, 32'h0, 1'b0, 3'b010, 5'd3);
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
    end
    check_eq("tmo_busy_cycles", busy_cnt, TB_TMO);
    check_eq("tmo_strobes", {27'h0, bus_rd_o, bus_wr_o}, 32'h0);
    @(posedge clk_i); #1 bus_ack_i = 1'b1;
    @(posedge clk_i); #1 bus_ack_i = 1'b0;
    @(negedge clk_i);
    check_eq("tmo_late_ack", {30'h0, busy_o, wb_valid_o}, 32'h0);
`else
    busy_cnt = 0;
`endif

    issue(1'b1, 4'h0, 32'h0000_9000, 32'h0, 1'b0, 3'b010, 5'd4);
    bus_accept_i = 1'b1;
    @(posedge clk_i); #1 bus_accept_i = 1'b0;
    @(negedge clk_i);
    check_eq("wait_busy", {31'h0 + busy_cnt * 0, busy_o}, 32'h1);
    rst_n_i = 1'b0;
    #1;
    check_eq("rst_mid_busy", {31'h0, busy_o}, 32'h0);
    check_eq("rst_mid_out", {26'h0, bus_rd_o, bus_wr_o, wb_valid_o},
             32'h0);
    check_eq("rst_mid_data", bus_addr_o | wb_data_o | fault_addr_o, 32'h0);
    @(posedge clk_i); #1 rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("sb_drained", sb_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
